// File: rtl/uriscv_lsu_mem_pkg.sv
// Shared types for the data-memory bus sequencer: FSM states, trap cause
// codes and the load func3 encodings used by lane extraction.
package uriscv_lsu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } lsu_state_t;

  localparam logic [3:0] CAUSE_LD_MISALIGNED = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS     = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS     = 4'd7;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;

  function automatic logic [3:0] fault_cause(input logic is_load, input logic misaligned);
    if (misaligned)
      return is_load ? CAUSE_LD_MISALIGNED : CAUSE_ST_MISALIGNED;
    return is_load ? CAUSE_LD_ACCESS : CAUSE_ST_ACCESS;
  endfunction

endpackage

// File: rtl/uriscv_lsu_align.sv
// Load-lane extraction: picks the addressed byte/half of a bus word and
// sign- or zero-extends it according to func3.
module uriscv_lsu_align
  import uriscv_lsu_mem_pkg::*;
(
  input  logic [1:0]  addr_lsb,
  input  logic [2:0]  func3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word[8*gi +: 8];
  end

  always_comb begin
    byte_sel = lane[addr_lsb];
    half_sel = addr_lsb[1] ? word[31:16] : word[15:0];
    case (func3)
      FUNC3_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      FUNC3_LBU: result = {24'd0, byte_sel};
      FUNC3_LH:  result = {{16{half_sel[15]}}, half_sel};
      FUNC3_LHU: result = {16'd0, half_sel};
      default:   result = word;  // lw and any unused encoding
    endcase
  end

endmodule

// File: rtl/uriscv_lsu_mem.sv
// Single-outstanding data-memory bus sequencer: latches one LSU request,
// drives it over the accept/ack bus and reports a result or a trap.
module uriscv_lsu_mem
  import uriscv_lsu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_i,
  input  logic [2:0]  func3_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_misaligned_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        load_o,
  output logic [31:0] result_o,
  output logic        fault_o,
  output logic [3:0]  fault_cause_o,
  output logic [31:0] fault_addr_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_data_wr_o,
  output logic        dmem_rd_o,
  output logic [3:0]  dmem_wr_o,
  input  logic        dmem_accept_i,
  input  logic        dmem_ack_i,
  input  logic        dmem_error_i,
  input  logic [31:0] dmem_data_rd_i
);

  localparam bit         WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  lsu_state_t  state_reg;
  logic [15:0] wdog_reg;
  logic [31:0] addr_reg;
  logic [2:0]  func3_reg;
  logic        rd_reg;

  logic [31:0] align_data;
  logic        can_issue;
  logic        issue_ok;
  logic        in_flight;
  logic        complete;
  logic        timed_out;

  uriscv_lsu_align u_align (
    .addr_lsb (addr_reg[1:0]),
    .func3    (func3_reg),
    .word     (dmem_data_rd_i),
    .result   (align_data)
  );

  // The misaligned-report cycle is not busy, so a new request may enter there.
  assign can_issue = (state_reg == ST_IDLE) || (state_reg == ST_FAULT);
  assign issue_ok  = can_issue && issue_i && (mem_rd_i || (|mem_wr_i));
  assign in_flight = (state_reg == ST_REQ) || (state_reg == ST_RESP);
  assign complete  = ((state_reg == ST_REQ) && dmem_accept_i && dmem_ack_i) ||
                     ((state_reg == ST_RESP) && dmem_ack_i);
  assign timed_out = WDOG_EN && in_flight && (wdog_reg == WDOG_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      wdog_reg       <= 16'd0;
      addr_reg       <= 32'd0;
      func3_reg      <= 3'd0;
      rd_reg         <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      load_o         <= 1'b0;
      result_o       <= 32'd0;
      fault_o        <= 1'b0;
      fault_cause_o  <= 4'd0;
      fault_addr_o   <= 32'd0;
      dmem_addr_o    <= 32'd0;
      dmem_data_wr_o <= 32'd0;
      dmem_rd_o      <= 1'b0;
      dmem_wr_o      <= 4'd0;
    end else begin
      done_o  <= 1'b0;
      load_o  <= 1'b0;
      fault_o <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_FAULT: begin
          state_reg <= ST_IDLE;
          busy_o    <= 1'b0;
          if (issue_ok) begin
            addr_reg  <= mem_addr_i;
            func3_reg <= func3_i;
            rd_reg    <= mem_rd_i;
            if (mem_misaligned_i) begin
              state_reg     <= ST_FAULT;
              fault_o       <= 1'b1;
              fault_cause_o <= fault_cause(mem_rd_i, 1'b1);
              fault_addr_o  <= mem_addr_i;
            end else begin
              state_reg      <= ST_REQ;
              busy_o         <= 1'b1;
              wdog_reg       <= 16'd0;
              dmem_addr_o    <= {mem_addr_i[31:2], 2'b00};
              dmem_data_wr_o <= mem_data_i;
              dmem_rd_o      <= mem_rd_i;
              dmem_wr_o      <= mem_rd_i ? 4'd0 : mem_wr_i;
            end
          end
        end

        ST_REQ, ST_RESP: begin
          if (complete || timed_out) begin
            state_reg <= ST_IDLE;
            busy_o    <= 1'b0;
            dmem_rd_o <= 1'b0;
            dmem_wr_o <= 4'd0;
            // A response arriving on the watchdog's last cycle still wins.
            if (complete && !dmem_error_i) begin
              done_o   <= 1'b1;
              load_o   <= rd_reg;
              result_o <= rd_reg ? align_data : 32'd0;
            end else begin
              fault_o       <= 1'b1;
              fault_cause_o <= fault_cause(rd_reg, 1'b0);
              fault_addr_o  <= addr_reg;
            end
          end else begin
            wdog_reg <= wdog_reg + 16'd1;
            if ((state_reg == ST_REQ) && dmem_accept_i) begin
              state_reg <= ST_RESP;
              dmem_rd_o <= 1'b0;
              dmem_wr_o <= 4'd0;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uriscv_lsu_mem.md
# uriscv_lsu_mem

Data-memory bus sequencer sitting directly downstream of the combinational LSU address/strobe generator. It latches one decoded load/store request (address, byte strobes, write data, misalignment flag), runs it over a single-outstanding request/accept/ack data-memory bus, and returns either an aligned, sign/zero-extended load result or a fault (misaligned, bus error, timeout) to the core's writeback/trap logic. It stalls the core while a transaction is in flight.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: cycles a request may stay in REQ+RESP before an access fault; 0 disables the watchdog (max 65535).

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  core clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- issue_i  in  1  core presents a load/store this cycle
- func3_i  in  3  instruction func3 (load extension select)
- mem_rd_i  in  1  load request from LSU
- mem_wr_i  in  4  store byte strobes from LSU
- mem_addr_i  in  32  effective address from LSU
- mem_data_i  in  32  lane-positioned store data from LSU
- mem_misaligned_i  in  1  misalignment flag from LSU
- busy_o  out  1  transaction in flight; core must hold
- done_o  out  1  one-cycle pulse: access completed without fault
- load_o  out  1  qualifies done_o: result_o is to be written back
- result_o  out  32  aligned, extended load data (0 for stores)
- fault_o  out  1  one-cycle pulse: access faulted
- fault_cause_o  out  4  4 ld-misaligned, 5 ld-access, 6 st-misaligned, 7 st-access
- fault_addr_o  out  32  faulting effective address
- dmem_addr_o  out  32  word address (addr[1:0] forced 0)
- dmem_data_wr_o  out  32  store data
- dmem_rd_o  out  1  read request
- dmem_wr_o  out  4  write byte strobes
- dmem_accept_i  in  1  bus accepts request this cycle
- dmem_ack_i  in  1  response valid this cycle
- dmem_error_i  in  1  response is a bus error (qualified by ack)
- dmem_data_rd_i  in  32  read data (qualified by ack)

## Operation
- States: IDLE, REQ (request driven, awaiting accept), RESP (awaiting ack), FAULT (one-cycle misaligned report).
- IDLE + issue_i + (mem_rd_i | |mem_wr_i): latch addr, strobes, data, func3, rd flag. If mem_misaligned_i -> FAULT (no bus activity); else -> REQ. issue_i with no rd/wr: ignored.
- issue_i outside IDLE: ignored (core contract: it holds while busy_o).
- REQ: dmem_rd_o / dmem_wr_o driven from latched values, stable until accept. accept & ack same cycle -> complete; accept only -> RESP.
- RESP: request outputs deasserted. ack -> complete, back to IDLE.
- Complete: error=0 -> done_o, load_o=rd flag, result_o = extracted data; error=1 -> fault_o, cause 5 (load) / 7 (store), fault_addr_o = latched addr.
- Extraction: lb/lbu byte lane addr[1:0], lh/lhu half lane addr[1], lw full word; lb/lh sign-extend, lbu/lhu zero-extend. func3 other than 000/001/010/100/101 treated as lw.
- Watchdog: 16-bit counter cleared on entering REQ, increments each REQ/RESP cycle; reaching TIMEOUT_CYCLES without completion -> access fault, IDLE. Later ack in IDLE ignored.
- FAULT: fault_o with cause 4/6, -> IDLE.

## Timing
- Reset: state IDLE, counter 0; all outputs 0 (busy_o, done_o, load_o, fault_o, dmem_rd_o, dmem_wr_o, result_o, fault_cause_o, fault_addr_o, dmem_addr_o, dmem_data_wr_o).
- Reset mid-transaction abandons it; no done/fault generated; stray ack after reset ignored.
- Issue cycle N -> dmem request visible N+1; busy_o high from N+1 through the cycle done_o/fault_o pulses inclusive is NOT required — busy_o high N+1 until the completion edge, low in the done/fault cycle.
- done_o/fault_o registered: pulse the cycle after ack (or after timeout/misalign detection). Best case load: issue N, accept+ack N+1, done_o N+2.
- Misaligned: issue N, fault_o N+1, no dmem strobe ever asserted.
- New issue accepted in the same cycle done_o/fault_o pulses.

## Structure
- Shared package/defines: fault cause codes, load func3 encodings, FSM state encoding.
- Sub-module uriscv_lsu_align: combinational load-lane extraction and extension (addr[1:0], func3, word in -> 32-bit result).

## Test plan
- lb addr 0x1003, bus word 0x80FF_1234, accept+ack same cycle -> done_o N+2, load_o=1, result_o=0xFFFF_FF80.
- lhu addr 0x1002, word 0x8001_0000 -> result_o=0x0000_8001; lh same -> 0xFFFF_8001.
- sw addr 0x2000 data 0xDEADBEEF, accept delayed 3 cycles -> dmem_wr_o=0xF held stable, busy_o high, done_o with load_o=0.
- lw with mem_misaligned_i=1 addr 0x3002 -> fault_o N+1, cause 4, fault_addr_o 0x3002, dmem_rd_o never high.
- sb addr 0x4001, ack with dmem_error_i=1 -> fault_o, cause 7, fault_addr_o 0x4001.
- TIMEOUT_CYCLES=8, no ack -> fault cause 5 after 8 busy cycles; late ack then ignored; rst_i in RESP -> all outputs 0 next cycle.
